inst_queue_mp: RTL and testbench

Parametrised multi-lane instruction queue between the fetch stage and the issue/decode stage. It accepts up to WR_LANES {pc, inst} pairs per cycle from fetch and presents up to RD_LANES head entries per cycle to issue. It provides exact occupancy, back-pressure, overflow detection and synchronous flush. It also tracks delay slots per lane, including a delay slot split across issue cycles.

---
 rtl/inst_queue_pkg.sv | 28 ++
 rtl/iq_lane_mux.sv | 20 ++
 rtl/inst_queue_mp.sv | 171 +++++++++++++++++
 tb/tb_inst_queue_mp.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/inst_queue_pkg.sv
// Shared types, default sizing and width helpers for the multi-lane instruction queue.
package inst_queue_pkg;

  localparam int IQ_DEPTH    = 16;
  localparam int IQ_DATA_W   = 32;
  localparam int IQ_ADDR_W   = 32;
  localparam int IQ_WR_LANES = 2;
  localparam int IQ_RD_LANES = 2;

  // Entry layout at the default widths; the queue stores {pc, inst} in this order.
  typedef struct packed {
    logic [IQ_ADDR_W-1:0] pc;
    logic [IQ_DATA_W-1:0] inst;
  } iq_entry_t;

  function automatic int iq_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int iq_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic bit iq_is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/iq_lane_mux.sv
// Circular index for one lane: entry (ptr + LANE) mod DEPTH and its contents.
module iq_lane_mux
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  parameter int W     = IQ_ADDR_W + IQ_DATA_W,
  parameter int LANE  = 0
) (
  input  logic [iq_ptr_w(DEPTH)-1:0] ptr_i,
  input  logic [DEPTH-1:0][W-1:0]    mem_i,
  output logic [iq_ptr_w(DEPTH)-1:0] idx_o,
  output logic [W-1:0]               data_o
);
  localparam int PTR_W = iq_ptr_w(DEPTH);

  // Power-of-two depth lets the adder wrap for free.
  assign idx_o  = ptr_i + PTR_W'(LANE);
  assign data_o = mem_i[idx_o];

endmodule

// File: rtl/inst_queue_mp.sv
// Multi-lane fetch-to-issue instruction queue with occupancy, overflow and delay-slot tracking.
module inst_queue_mp
  import inst_queue_pkg::*;
#(
  parameter int DEPTH    = IQ_DEPTH,
  parameter int DATA_W   = IQ_DATA_W,
  parameter int ADDR_W   = IQ_ADDR_W,
  parameter int WR_LANES = IQ_WR_LANES,
  parameter int RD_LANES = IQ_RD_LANES
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic [iq_cnt_w(WR_LANES)-1:0]     wr_cnt,
  input  logic [WR_LANES-1:0][ADDR_W-1:0]   wr_pc,
  input  logic [WR_LANES-1:0][DATA_W-1:0]   wr_inst,
  output logic                              wr_ready,
  input  logic                              rd_en,
  input  logic [iq_cnt_w(RD_LANES)-1:0]     rd_cnt,
  input  logic [RD_LANES-1:0]               issue_is_branch,
  output logic [RD_LANES-1:0]               rd_valid,
  output logic [RD_LANES-1:0][ADDR_W-1:0]   rd_pc,
  output logic [RD_LANES-1:0][DATA_W-1:0]   rd_inst,
  output logic [RD_LANES-1:0]               rd_in_ds,
  output logic [iq_ptr_w(DEPTH):0]          count,
  output logic [iq_ptr_w(DEPTH):0]          free,
  output logic                              empty,
  output logic                              full,
  output logic                              overflow
);
  localparam int PTR_W = iq_ptr_w(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + DATA_W;

  if (!iq_is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
    $error("inst_queue_mp: DEPTH must be a power of two and at least 4");
  end
  if (WR_LANES < 1 || WR_LANES > 4 || WR_LANES > DEPTH / 2) begin : g_bad_wr
    $error("inst_queue_mp: WR_LANES must be 1..4 and no more than DEPTH/2");
  end
  if (RD_LANES < 1 || RD_LANES > 4 || RD_LANES > DEPTH / 2) begin : g_bad_rd
    $error("inst_queue_mp: RD_LANES must be 1..4 and no more than DEPTH/2");
  end

  logic [DEPTH-1:0][ENT_W-1:0] mem_q;
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic                        ds_pending_q, ds_pending_d;
  logic                        overflow_q, overflow_d;

  logic [CNT_W-1:0]            free_c;
  logic [CNT_W-1:0]            wr_req, rd_req;
  logic [CNT_W-1:0]            push, pop;
  logic                        drop;

  logic [WR_LANES-1:0][PTR_W-1:0] wr_idx;
  logic [WR_LANES-1:0][ENT_W-1:0] unused_wr_ent;
  logic [RD_LANES-1:0][PTR_W-1:0] unused_rd_idx;
  logic [RD_LANES-1:0][ENT_W-1:0] rd_ent;

  // ---------------------------------------------------------------------------
  // Occupancy, push/pop sizing and next state
  // ---------------------------------------------------------------------------
  always_comb begin
    free_c = CNT_W'(DEPTH) - count_q;

    // Lane counts beyond the physical lane width are treated as the full width.
    wr_req = (CNT_W'(wr_cnt) > CNT_W'(WR_LANES)) ? CNT_W'(WR_LANES) : CNT_W'(wr_cnt);
    rd_req = (CNT_W'(rd_cnt) > CNT_W'(RD_LANES)) ? CNT_W'(RD_LANES) : CNT_W'(rd_cnt);

    // Room is judged before this cycle's pops: a group never relies on same-cycle drain.
    drop = wr_req > free_c;
    push = drop ? '0 : wr_req;
    pop  = '0;
    if (rd_en) pop = (rd_req < count_q) ? rd_req : count_q;

    wr_ptr_d     = wr_ptr_q + push[PTR_W-1:0];
    rd_ptr_d     = rd_ptr_q + pop[PTR_W-1:0];
    count_d      = count_q + push - pop;
    overflow_d   = drop;
    ds_pending_d = ds_pending_q;
    // The last lane popped decides whether the next head is a delay slot.
    for (int i = 0; i < RD_LANES; i++) begin
      if (pop == CNT_W'(i + 1)) ds_pending_d = issue_is_branch[i];
    end

    if (flush) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      overflow_d   = 1'b0;
      ds_pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ds_pending_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ds_pending_q <= ds_pending_d;
      overflow_q   <= overflow_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage: write lanes land at wr_ptr + i; no reset on the array
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < WR_LANES; i++) begin : g_wr
    iq_lane_mux #(
      .DEPTH (DEPTH),
      .W     (ENT_W),
      .LANE  (i)
    ) u_wr_mux (
      .ptr_i  (wr_ptr_q),
      .mem_i  (mem_q),
      .idx_o  (wr_idx[i]),
      .data_o (unused_wr_ent[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!flush) begin
      for (int i = 0; i < WR_LANES; i++) begin
        if (CNT_W'(i) < push) mem_q[wr_idx[i]] <= {wr_pc[i], wr_inst[i]};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read view: combinational from registered state, invalid lanes forced to zero
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < RD_LANES; i++) begin : g_rd
    iq_lane_mux #(
      .DEPTH (DEPTH),
      .W     (ENT_W),
      .LANE  (i)
    ) u_rd_mux (
      .ptr_i  (rd_ptr_q),
      .mem_i  (mem_q),
      .idx_o  (unused_rd_idx[i]),
      .data_o (rd_ent[i])
    );

    assign rd_valid[i] = count_q > CNT_W'(i);
    assign rd_pc[i]    = rd_valid[i] ? rd_ent[i][ENT_W-1:DATA_W] : '0;
    assign rd_inst[i]  = rd_valid[i] ? rd_ent[i][DATA_W-1:0]     : '0;

    // Lane 0's slot may belong to a branch issued in an earlier cycle.
    if (i == 0) begin : g_ds_head
      assign rd_in_ds[i] = ds_pending_q & rd_valid[i];
    end else begin : g_ds_lane
      assign rd_in_ds[i] = issue_is_branch[i-1] & rd_valid[i];
    end
  end

  assign count    = count_q;
  assign free     = free_c;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign wr_ready = (free_c >= CNT_W'(WR_LANES));
  assign overflow = overflow_q;

endmodule

// File: tb/tb_inst_queue_mp.sv
// Scoreboard bench for inst_queue_mp: a queue model tracks contents, delay slot and overflow.
module tb_inst_queue_mp;
  import inst_queue_pkg::*;

  localparam int DEPTH = 16;
  localparam int WL    = 2;
  localparam int RL    = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  flush = 1'b0;
  logic [1:0]            wr_cnt = '0;
  logic [WL-1:0][31:0]   wr_pc = '0;
  logic [WL-1:0][31:0]   wr_inst = '0;
  logic                  wr_ready;
  logic                  rd_en = 1'b0;
  logic [1:0]            rd_cnt = '0;
  logic [RL-1:0]         issue_is_branch = '0;
  logic [RL-1:0]         rd_valid;
  logic [RL-1:0][31:0]   rd_pc;
  logic [RL-1:0][31:0]   rd_inst;
  logic [RL-1:0]         rd_in_ds;
  logic [4:0]            count;
  logic [4:0]            free;
  logic                  empty;
  logic                  full;
  logic                  overflow;

  inst_queue_mp #(
    .DEPTH    (DEPTH),
    .DATA_W   (32),
    .ADDR_W   (32),
    .WR_LANES (WL),
    .RD_LANES (RL)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .wr_cnt          (wr_cnt),
    .wr_pc           (wr_pc),
    .wr_inst         (wr_inst),
    .wr_ready        (wr_ready),
    .rd_en           (rd_en),
    .rd_cnt          (rd_cnt),
    .issue_is_branch (issue_is_branch),
    .rd_valid        (rd_valid),
    .rd_pc           (rd_pc),
    .rd_inst         (rd_inst),
    .rd_in_ds        (rd_in_ds),
    .count           (count),
    .free            (free),
    .empty           (empty),
    .full            (full),
    .overflow        (overflow)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  iq_entry_t   sb[$];
  bit          m_ds  = 1'b0;
  bit          m_ovf = 1'b0;
  logic [31:0] next_pc;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input logic [1:0] br);
    int          sz;
    logic [31:0] e_pc, e_inst;
    logic        e_ds;
    sz = sb.size();
    chk("count",    64'(count),    64'(sz));
    chk("free",     64'(free),     64'(DEPTH - sz));
    chk("empty",    64'(empty),    64'(sz == 0));
    chk("full",     64'(full),     64'(sz == DEPTH));
    chk("wr_ready", 64'(wr_ready), 64'((DEPTH - sz) >= WL));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    for (int i = 0; i < RL; i++) begin
      e_pc   = '0;
      e_inst = '0;
      if (i < sz) begin
        e_pc   = sb[i].pc;
        e_inst = sb[i].inst;
      end
      if (i == 0) e_ds = m_ds && (sz > 0);
      else        e_ds = br[i-1] && (i < sz);
      chk($sformatf("rd_valid[%0d]", i), 64'(rd_valid[i]), 64'(i < sz));
      chk($sformatf("rd_pc[%0d]", i),    64'(rd_pc[i]),    64'(e_pc));
      chk($sformatf("rd_inst[%0d]", i),  64'(rd_inst[i]),  64'(e_inst));
      chk($sformatf("rd_in_ds[%0d]", i), 64'(rd_in_ds[i]), 64'(e_ds));
    end
  endtask

  // One cycle: drive at edge+1, check at edge+2, update model across the edge.
  task automatic step(input int wc, input int rc, input bit ren, input logic [1:0] br, input bit fl);
    int sz, pop, push;
    wr_cnt          = 2'(wc);
    rd_cnt          = 2'(rc);
    rd_en           = ren;
    issue_is_branch = br;
    flush           = fl;
    for (int i = 0; i < WL; i++) begin
      wr_pc[i]   = next_pc + 32'(4 * i);
      wr_inst[i] = $urandom;
    end
    #1;
    check_outputs(br);
    sz   = sb.size();
    pop  = ren ? ((rc < sz) ? rc : sz) : 0;
    push = (wc <= DEPTH - sz) ? wc : 0;
    @(posedge clk);
    if (fl) begin
      sb.delete();
      m_ds  = 1'b0;
      m_ovf = 1'b0;
    end else begin
      if (pop > 0) m_ds = br[pop-1];
      for (int i = 0; i < pop; i++) void'(sb.pop_front());
      for (int i = 0; i < push; i++) sb.push_back(iq_entry_t'{pc: wr_pc[i], inst: wr_inst[i]});
      m_ovf   = (wc > DEPTH - sz);
      next_pc = next_pc + 32'(4 * push);
    end
    #1;
  endtask

  initial begin
    next_pc = 32'h1000;
    repeat (2) @(posedge clk);
    #1;
    check_outputs(2'b00);
    rst = 1'b0;

    // Fill to full with rd_en low, then one dropped write.
    repeat (8) step(2, 0, 1'b0, 2'b00, 1'b0);
    chk("full_after_fill", 64'(full), 64'(1));
    step(1, 0, 1'b0, 2'b00, 1'b0);
    step(0, 0, 1'b0, 2'b00, 1'b0);
    step(0, 0, 1'b0, 2'b00, 1'b0);

    // Drain to 3, then pop 2 while pushing 2.
    repeat (6) step(0, 2, 1'b1, 2'b00, 1'b0);
    step(0, 1, 1'b1, 2'b00, 1'b0);
    step(2, 2, 1'b1, 2'b00, 1'b0);
    step(0, 0, 1'b0, 2'b00, 1'b0);

    // Wrap across index 15 -> 0.
    step(0, 0, 1'b0, 2'b00, 1'b1);
    repeat (7) step(2, 0, 1'b0, 2'b00, 1'b0);
    repeat (7) step(0, 2, 1'b1, 2'b00, 1'b0);
    next_pc = 32'h2000;
    repeat (2) step(2, 0, 1'b0, 2'b00, 1'b0);
    chk("wrap_pc0", 64'(rd_pc[0]), 64'(32'h2000));
    chk("wrap_pc1", 64'(rd_pc[1]), 64'(32'h2004));
    chk("wrap_cnt", 64'(count), 64'(4));

    // Branch alone in lane 0; its slot waits through a stall.
    step(0, 1, 1'b1, 2'b01, 1'b0);
    repeat (3) step(0, 0, 1'b0, 2'b00, 1'b0);
    step(0, 1, 1'b1, 2'b00, 1'b0);
    step(0, 0, 1'b0, 2'b01, 1'b0);

    // Over-requested pop is clipped.
    step(0, 1, 1'b1, 2'b00, 1'b0);
    step(0, 2, 1'b1, 2'b00, 1'b0);
    step(0, 0, 1'b0, 2'b00, 1'b0);

    // Flush at count 9 with a pending delay slot and concurrent traffic.
    repeat (5) step(2, 0, 1'b0, 2'b00, 1'b0);
    step(0, 1, 1'b1, 2'b01, 1'b0);
    step(2, 2, 1'b1, 2'b01, 1'b1);
    step(0, 0, 1'b0, 2'b01, 1'b0);

    // Mixed random traffic.
    repeat (80) step(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                     1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                     ($urandom_range(0, 15) == 0));

    // Asynchronous reset mid-stream, checked before any clock edge.
    step(2, 0, 1'b0, 2'b00, 1'b0);
    step(2, 1, 1'b1, 2'b01, 1'b0);
    rst = 1'b1;
    #2;
    sb.delete();
    m_ds  = 1'b0;
    m_ovf = 1'b0;
    check_outputs(issue_is_branch);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
